ip_sdram_arbiter: RTL and testbench
===================================

// Module: ip_sdram_arbiter
// PURPOSE
//  Shares the 128-bit DDR3 controller request port between two requesters: port 0 (CPU memory bridge) and port 1 (test/DMA).
//  Picks one request per slot and holds it stable on the controller port until the controller accepts it.
//  Tags every read with its port ID and steers each read return back to the requester that issued it.
//  Sits between the requesters and ip_sdram, in the clk (74.25 MHz, ip_sdram clk_out) domain.
// PARAMETERS
//  ADDR_W    27   DRAM word address width ([26:24] bank, [23:10] row, [9:0] column)
//  DATA_W    128  data width; mask width is DATA_W/8
//  TAG_DEPTH 8    outstanding-read tag FIFO depth; power of 2, >=2
// PORTS
//  clk              in  1        system clock
//  reset            in  1        asynchronous, active-high reset
//  sdram_init_busy  in  1        1: DDR3 initialising, no grants issued
//  pN_address       in  ADDR_W   port N (N=0,1) word address
//  pN_write         in  1        port N direction: 0 read, 1 write
//  pN_valid         in  1        port N request valid
//  pN_ready         out 1        port N request accepted; single-cycle pulse
//  pN_wdata         in  DATA_W   port N write data
//  pN_wdata_mask    in  DATA_W/8 port N byte mask, 1 = byte not written
//  pN_rdata         out DATA_W   port N read data
//  pN_rdata_valid   out 1        port N read data strobe
//  dram_address     out ADDR_W   to controller
//  dram_write       out 1        to controller
//  dram_valid       out 1        to controller
//  dram_ready       in  1        from controller
//  dram_wdata       out DATA_W   to controller
//  dram_wdata_mask  out DATA_W/8 to controller
//  dram_rdata       in  DATA_W   from controller
//  dram_rdata_valid in  1        from controller
//  err_orphan       out 1        sticky: read data returned with no outstanding tag
// BEHAVIOUR
//  Reset values: all outputs 0; FSM in IDLE; tag FIFO empty; round-robin pointer = port 0.
//  Port handshake: requester holds valid and all fields stable until pN_ready=1 in the same cycle; pN_ready never asserts without pN_valid.
//  Eligibility: pN is eligible when pN_valid=1, sdram_init_busy=0, and (pN_write=1 or tag FIFO not full).
//  FSM IDLE:
//   - If any port is eligible, the winner's fields are registered onto the dram_* outputs.
//   - Winner's pN_ready=1 in that cycle; FSM goes to ISSUE. No eligible port: stay in IDLE.
//  FSM ISSUE:
//   - dram_valid=1; dram_* outputs held stable.
//   - On dram_ready=1: dram_valid falls the next cycle; FSM returns to IDLE. For a read, the winner's port ID is pushed into the tag FIFO in that cycle.
//  Timing: accept at cycle T gives dram_valid=1 from T+1. Peak throughput is 1 request per 2 cycles.
//  Read return: on dram_rdata_valid, the tag FIFO pops; pN_rdata <= dram_rdata and pN_rdata_valid=1 one cycle later for the popped port.
//   - The other port's rdata_valid stays 0; its rdata holds the last value.
//  Push and pop in the same cycle: both occur; occupancy unchanged (legal even when full).
//  dram_rdata_valid with tag FIFO empty: data dropped, no rdata_valid, err_orphan set until reset.
//  Tag FIFO full: reads blocked (no ready); writes still granted.
//  sdram_init_busy rising while in ISSUE: the current request completes normally; only new grants are blocked.
//  Reset mid-operation: async clear of everything; outstanding reads and the pending request are discarded.
// CONFIGURATION
//  SDRAM_ARB_ROUND_ROBIN_EN defined:
//   - When both ports are eligible, the port not granted last wins.
//   - The pointer updates on each grant.
//  SDRAM_ARB_ROUND_ROBIN_EN undefined:
//   - Fixed priority, port 0 always wins.
//   - The pointer logic is not built.
// TESTING
//  1. p0 write addr 0x0000100, mask 0x0000, dram_ready tied 1 -> p0_ready at T, dram_valid high only at T+1 with matching fields; FIFO stays empty.
//  2. p1 read addr 0x1234567, controller returns 0xA5..A5 three cycles later -> p1_rdata_valid one cycle after dram_rdata_valid, p1_rdata=0xA5..A5, p0_rdata_valid=0.
//  3. p0 and p1 both valid for 4 requests -> RR: grants p0,p1,p0,p1; fixed: p0 x4 before any p1 grant.
//  4. 8 p0 reads with no returns, then a 9th p0 read and a p1 write -> 9th read not accepted, p1 write granted; one return frees a slot and the 9th read is granted.
//  5. sdram_init_busy=1 with p0_valid=1 for 20 cycles -> no ready, dram_valid=0; grant 1 cycle after busy falls.
//  6. dram_rdata_valid with FIFO empty -> err_orphan=1 and stays 1; async reset mid-ISSUE -> all outputs 0 immediately, err_orphan cleared.

Source files
------------

// File: rtl/ip_sdram_arbiter_if.sv
// Request / read-return bus between a requester and the DDR3 controller port.
// The requester side uses the master modport; the arbiter presents slave to requesters, master to the controller.
interface ip_sdram_arbiter_if #(
    parameter int unsigned ADDR_W = 27,
    parameter int unsigned DATA_W = 128
);
    localparam int unsigned MASK_W = DATA_W / 8;

    logic [ADDR_W-1:0] address;
    logic              write;
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] wdata;
    logic [MASK_W-1:0] wdata_mask;
    logic [DATA_W-1:0] rdata;
    logic              rdata_valid;

    modport master (
        output address, write, valid, wdata, wdata_mask,
        input  ready, rdata, rdata_valid
    );

    modport slave (
        input  address, write, valid, wdata, wdata_mask,
        output ready, rdata, rdata_valid
    );
endinterface

// File: rtl/ip_sdram_arbiter.sv
// Two-port arbiter for the DDR3 controller request port with read-tag steering of returns.
// Optional macro SDRAM_ARB_ROUND_ROBIN_EN: round-robin on contention; otherwise fixed priority to port 0.
module ip_sdram_arbiter #(
    parameter int unsigned ADDR_W    = 27,
    parameter int unsigned DATA_W    = 128,
    parameter int unsigned TAG_DEPTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sdram_init_busy,
    ip_sdram_arbiter_if.slave  p0,
    ip_sdram_arbiter_if.slave  p1,
    ip_sdram_arbiter_if.master dram,
    output logic               err_orphan
);
    localparam int unsigned PTR_W = $clog2(TAG_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    state_t               state;
    logic [TAG_DEPTH-1:0] tag_mem;
    logic [PTR_W-1:0]     tag_wr_ptr;
    logic [PTR_W-1:0]     tag_rd_ptr;
    logic [CNT_W-1:0]     tag_count;
    logic                 tag_full;
    logic                 tag_empty;
    logic                 tag_push;
    logic                 tag_pop;
    logic                 issue_port;
    logic                 elig0;
    logic                 elig1;
    logic                 grant;
    logic                 win;

    assign tag_full  = (tag_count == CNT_W'(TAG_DEPTH));
    assign tag_empty = (tag_count == '0);

    // Reads need a free tag slot; writes never do.
    assign elig0 = p0.valid && !sdram_init_busy && (p0.write || !tag_full);
    assign elig1 = p1.valid && !sdram_init_busy && (p1.write || !tag_full);
    assign grant = (state == IDLE) && (elig0 || elig1) && !reset;

`ifdef SDRAM_ARB_ROUND_ROBIN_EN
    logic rr_ptr;
    // rr_ptr names the port that wins a tie; it flips away from each grantee.
    assign win = elig1 && (!elig0 || rr_ptr);
`else
    assign win = !elig0;
`endif

    assign p0.ready = grant && !win;
    assign p1.ready = grant && win;

    assign tag_push = (state == ISSUE) && dram.ready && !dram.write;
    assign tag_pop  = dram.rdata_valid && !tag_empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            dram.address    <= '0;
            dram.write      <= 1'b0;
            dram.valid      <= 1'b0;
            dram.wdata      <= '0;
            dram.wdata_mask <= '0;
            issue_port      <= 1'b0;
            tag_mem         <= '0;
            tag_wr_ptr      <= '0;
            tag_rd_ptr      <= '0;
            tag_count       <= '0;
            p0.rdata        <= '0;
            p0.rdata_valid  <= 1'b0;
            p1.rdata        <= '0;
            p1.rdata_valid  <= 1'b0;
            err_orphan      <= 1'b0;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
            rr_ptr          <= 1'b0;
`endif
        end else begin
            p0.rdata_valid <= 1'b0;
            p1.rdata_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (grant) begin
                        dram.address    <= win ? p1.address    : p0.address;
                        dram.write      <= win ? p1.write      : p0.write;
                        dram.wdata      <= win ? p1.wdata      : p0.wdata;
                        dram.wdata_mask <= win ? p1.wdata_mask : p0.wdata_mask;
                        dram.valid      <= 1'b1;
                        issue_port      <= win;
                        state           <= ISSUE;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
                        rr_ptr          <= !win;
`endif
                    end
                end
                ISSUE: begin
                    if (dram.ready) begin
                        dram.valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (tag_push) begin
                tag_mem[tag_wr_ptr] <= issue_port;
                tag_wr_ptr          <= tag_wr_ptr + PTR_W'(1);
            end

            // Steer the return to the port recorded at the head of the tag FIFO.
            if (tag_pop) begin
                if (tag_mem[tag_rd_ptr]) begin
                    p1.rdata       <= dram.rdata;
                    p1.rdata_valid <= 1'b1;
                end else begin
                    p0.rdata       <= dram.rdata;
                    p0.rdata_valid <= 1'b1;
                end
                tag_rd_ptr <= tag_rd_ptr + PTR_W'(1);
            end

            if (dram.rdata_valid && tag_empty) begin
                err_orphan <= 1'b1;
            end

            case ({tag_push, tag_pop})
                2'b10:   tag_count <= tag_count + CNT_W'(1);
                2'b01:   tag_count <= tag_count - CNT_W'(1);
                default: tag_count <= tag_count;
            endcase
        end
    end
endmodule

// File: tb/tb_ip_sdram_arbiter.sv
// Randomized scoreboard bench for ip_sdram_arbiter against a queue-based reference model.
module tb_ip_sdram_arbiter;
    localparam int ADDR_W    = 27;
    localparam int DATA_W    = 128;
    localparam int MASK_W    = DATA_W / 8;
    localparam int TAG_DEPTH = 8;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic              write;
        logic [DATA_W-1:0] wdata;
        logic [MASK_W-1:0] mask;
    } req_t;

    typedef struct {
        logic              port;
        logic [DATA_W-1:0] data;
    } rd_t;

    logic clk = 1'b0;
    logic reset;
    logic sdram_init_busy;
    logic err_orphan;

    ip_sdram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) p0_if ();
    ip_sdram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) p1_if ();
    ip_sdram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dram_if ();

    ip_sdram_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_DEPTH(TAG_DEPTH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .sdram_init_busy(sdram_init_busy),
        .p0(p0_if),
        .p1(p1_if),
        .dram(dram_if),
        .err_orphan(err_orphan)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Stimulus knobs (percent probabilities).
    int unsigned req_pct[2];
    int unsigned wr_pct[2];
    int unsigned rdy_pct;
    int unsigned ret_pct;
    logic        ret_en;
    logic        busy_knob;
    logic        force_orphan;

    // Requester state.
    logic              rq_act[2];
    logic              rq_write[2];
    logic [ADDR_W-1:0] rq_addr[2];
    logic [DATA_W-1:0] rq_wdata[2];
    logic [MASK_W-1:0] rq_mask[2];

    // Reference model state.
    logic   pending;
    logic   iss_port;
    logic   iss_write;
    logic   rr_next;
    logic   orphan_m;
    logic   outstanding[$];
    req_t   exp_req[$];
    rd_t    exp_rd[$];

    task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DATA_W-1:0] rand_data();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic drive_ports();
        p0_if.valid = rq_act[0]; p0_if.write = rq_write[0]; p0_if.address = rq_addr[0];
        p0_if.wdata = rq_wdata[0]; p0_if.wdata_mask = rq_mask[0];
        p1_if.valid = rq_act[1]; p1_if.write = rq_write[1]; p1_if.address = rq_addr[1];
        p1_if.wdata = rq_wdata[1]; p1_if.wdata_mask = rq_mask[1];
    endtask

    task automatic model_clear();
        pending = 1'b0; iss_port = 1'b0; iss_write = 1'b0; rr_next = 1'b0; orphan_m = 1'b0;
        outstanding.delete(); exp_req.delete(); exp_rd.delete();
        for (int k = 0; k < 2; k++) begin
            rq_act[k] = 1'b0; rq_write[k] = 1'b0; rq_addr[k] = '0; rq_wdata[k] = '0; rq_mask[k] = '0;
        end
        drive_ports();
        dram_if.ready = 1'b0; dram_if.rdata_valid = 1'b0; dram_if.rdata = '0;
        sdram_init_busy = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_p0_ready"}, DATA_W'(p0_if.ready), '0);
        check({tag, "_p1_ready"}, DATA_W'(p1_if.ready), '0);
        check({tag, "_p0_rvalid"}, DATA_W'(p0_if.rdata_valid), '0);
        check({tag, "_p1_rvalid"}, DATA_W'(p1_if.rdata_valid), '0);
        check({tag, "_p0_rdata"}, p0_if.rdata, '0);
        check({tag, "_p1_rdata"}, p1_if.rdata, '0);
        check({tag, "_dram_valid"}, DATA_W'(dram_if.valid), '0);
        check({tag, "_dram_addr"}, DATA_W'(dram_if.address), '0);
        check({tag, "_dram_write"}, DATA_W'(dram_if.write), '0);
        check({tag, "_dram_wdata"}, dram_if.wdata, '0);
        check({tag, "_dram_mask"}, DATA_W'(dram_if.wdata_mask), '0);
        check({tag, "_err_orphan"}, DATA_W'(err_orphan), '0);
    endtask

    // One clock of stimulus plus the per-cycle model prediction.
    task automatic step();
        logic ctrl_rdy, do_ret, e0, e1, win, g0, g1, p;
        logic [DATA_W-1:0] rdat;
        req_t r;
        rd_t  rd;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            if (!rq_act[k] && ($urandom_range(0, 99) < req_pct[k])) begin
                rq_act[k]   = 1'b1;
                rq_write[k] = ($urandom_range(0, 99) < wr_pct[k]);
                rq_addr[k]  = ADDR_W'($urandom());
                rq_wdata[k] = rand_data();
                rq_mask[k]  = MASK_W'($urandom());
            end
        end
        drive_ports();
        sdram_init_busy = busy_knob;
        ctrl_rdy = ($urandom_range(0, 99) < rdy_pct);
        dram_if.ready = ctrl_rdy;
        do_ret = force_orphan || (ret_en && (outstanding.size() > 0) && ($urandom_range(0, 99) < ret_pct));
        rdat = rand_data();
        dram_if.rdata_valid = do_ret;
        dram_if.rdata = rdat;
        #1;
        e0  = rq_act[0] && !busy_knob && (rq_write[0] || (outstanding.size() < TAG_DEPTH));
        e1  = rq_act[1] && !busy_knob && (rq_write[1] || (outstanding.size() < TAG_DEPTH));
        win = (e0 && e1) ? (RR && rr_next) : e1;
        g0  = !pending && (e0 || e1) && !win;
        g1  = !pending && (e0 || e1) && win;
        check("p0_ready", DATA_W'(p0_if.ready), DATA_W'(g0));
        check("p1_ready", DATA_W'(p1_if.ready), DATA_W'(g1));
        check("dram_valid", DATA_W'(dram_if.valid), DATA_W'(pending));
        check("err_orphan", DATA_W'(err_orphan), DATA_W'(orphan_m));
        if (do_ret) begin
            if (outstanding.size() > 0) begin
                p = outstanding.pop_front();
                rd.port = p; rd.data = rdat;
                exp_rd.push_back(rd);
            end else begin
                orphan_m = 1'b1;
            end
        end
        if (pending && ctrl_rdy) begin
            pending = 1'b0;
            if (!iss_write) outstanding.push_back(iss_port);
        end
        if (g0 || g1) begin
            r.addr = rq_addr[win]; r.write = rq_write[win]; r.wdata = rq_wdata[win]; r.mask = rq_mask[win];
            exp_req.push_back(r);
            pending = 1'b1; iss_port = win; iss_write = rq_write[win];
            rr_next = !win;
            rq_act[win] = 1'b0;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Monitor: compares controller-side requests and read returns against the scoreboard.
    initial begin
        req_t r;
        rd_t  rd;
        forever begin
            @(negedge clk);
            #3;
            if (dram_if.valid) begin
                check("dram_req_expected", DATA_W'(exp_req.size() != 0), DATA_W'(1));
                if (exp_req.size() != 0) begin
                    r = exp_req[0];
                    check("dram_address", DATA_W'(dram_if.address), DATA_W'(r.addr));
                    check("dram_write", DATA_W'(dram_if.write), DATA_W'(r.write));
                    check("dram_wdata", dram_if.wdata, r.wdata);
                    check("dram_mask", DATA_W'(dram_if.wdata_mask), DATA_W'(r.mask));
                    if (dram_if.ready) void'(exp_req.pop_front());
                end
            end
            if (p0_if.rdata_valid || p1_if.rdata_valid) begin
                check("rvalid_onehot", DATA_W'(p0_if.rdata_valid && p1_if.rdata_valid), '0);
                check("rd_expected", DATA_W'(exp_rd.size() != 0), DATA_W'(1));
                if (exp_rd.size() != 0) begin
                    rd = exp_rd.pop_front();
                    check("rd_port", DATA_W'(p1_if.rdata_valid), DATA_W'(rd.port));
                    check("rd_data", rd.port ? p1_if.rdata : p0_if.rdata, rd.data);
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        req_pct = '{0, 0}; wr_pct = '{0, 0};
        rdy_pct = 0; ret_pct = 0; ret_en = 1'b0; busy_knob = 1'b0; force_orphan = 1'b0;
        model_clear();
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;

        // Single writes from port 0 with an always-ready controller.
        req_pct = '{100, 0}; wr_pct = '{100, 0}; rdy_pct = 100;
        run(8);

        // Mixed random traffic.
        req_pct = '{50, 50}; wr_pct = '{50, 50}; rdy_pct = 60; ret_en = 1'b1; ret_pct = 30;
        run(1500);

        // Both ports always requesting.
        req_pct = '{100, 100}; rdy_pct = 100;
        run(200);

        // Tag FIFO fills with port-0 reads while port-1 writes keep flowing.
        req_pct = '{100, 40}; wr_pct = '{0, 100}; rdy_pct = 70; ret_en = 1'b0;
        run(80);
        ret_en = 1'b1; ret_pct = 20;
        run(80);

        // Controller still initialising.
        req_pct = '{100, 0}; wr_pct = '{50, 0}; busy_knob = 1'b1;
        run(20);
        busy_knob = 1'b0;
        run(30);

        // Drain, then a return with nothing outstanding.
        req_pct = '{0, 0}; rdy_pct = 100; ret_pct = 100;
        run(40);
        force_orphan = 1'b1;
        run(1);
        force_orphan = 1'b0;
        run(6);

        // Asynchronous reset while a request sits on the controller port.
        req_pct = '{100, 0}; wr_pct = '{100, 0}; rdy_pct = 0;
        run(3);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("midreset");
        model_clear();
        repeat (2) @(negedge clk);
        reset = 1'b0;

        req_pct = '{60, 60}; wr_pct = '{40, 40}; rdy_pct = 50; ret_pct = 40;
        run(300);
        req_pct = '{0, 0}; rdy_pct = 100; ret_pct = 100;
        run(40);
        check("req_queue_drained", DATA_W'(exp_req.size()), '0);
        check("rd_queue_drained", DATA_W'(exp_rd.size()), '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
